stm32_bus_master: RTL
=====================

# stm32_bus_master

Initiator side of the 4-bit nibble bus between the MCU and the DDC FPGA core. It accepts one command at a time over a valid/ready handshake, drives the sync strobe and command nibble, then either serialises write payloads (tuning parameters, TX I/Q) or samples read payloads (status, RX I/Q) from the responder. It is used for on-FPGA self-test and loopback, and as the bus driver for a companion FPGA standing in for the MCU.

## Interface
- RD_LAT, 2, beats from the command beat to the first read sample; 2 matches a directly wired responder with registered outputs; legal range 1..4.
- IDLE_GAP, 0, minimum number of sync-low idle cycles inserted after each transaction; range 0..15.
- clk_in  in  1  system clock; all logic on its rising edge.
- reset  in  1  synchronous, active-high reset.
- cmd_valid  in  1  command request.
- cmd_ready  out  1  master can accept a command.
- cmd_op  in  2  operation: 0 = params, 1 = status, 2 = tx_iq, 3 = rx_iq.
- cmd_preamp  in  1  preamp flag; used by params.
- cmd_tx  in  1  TX flag; used by params.
- cmd_freq  in  22  unsigned tuning word; used by params.
- cmd_tx_i, cmd_tx_q  in  16 each  signed TX samples; used by tx_iq.
- BUS_DATA_OUT  out  4  nibble to the responder's data input.
- BUS_SYNC  out  1  command strobe to the responder.
- BUS_DATA_IN  in  4  nibble from the responder's data output.
- rsp_valid  out  1  one-cycle pulse marking transaction completion.
- rsp_op  out  2  op of the completed transaction.
- rsp_adc_otr  out  1  ADC overrange flag, from status.
- rsp_rx_i, rsp_rx_q  out  16 each  signed RX samples, from rx_iq.
- busy  out  1  high whenever the FSM is not in IDLE.

## Operation
- **Reset values.** All outputs are 0 except cmd_ready = 1. The FSM enters IDLE and the beat counter clears.
- **Accept.** A command is accepted on the edge where cmd_valid & cmd_ready. All cmd_* fields are captured on that edge; later changes to them have no effect.
- **Command beat (beat 0).** Occupies the cycle after accept. BUS_SYNC = 1 and BUS_DATA_OUT = cmd_op + 1, giving bus codes 1, 2, 3, 4. BUS_SYNC is 1 in no other cycle.
- **Write nibbles.** Beat k is the k-th cycle after the command beat.
  - params, beats 1..7: {cmd_tx, cmd_preamp, 2'b00}, {2'b00, freq[21:20]}, freq[19:16], freq[15:12], freq[11:8], freq[7:4], freq[3:0].
  - tx_iq, beats 1..8: Q[15:12], Q[11:8], Q[7:4], Q[3:0], then I[15:12] through I[3:0].
- **Read sampling.** BUS_DATA_IN is sampled at the end of each read beat.
  - status: one sample at the end of beat RD_LAT. rsp_adc_otr takes bit 0; bits 3:1 are ignored.
  - rx_iq: samples at the ends of beats RD_LAT..RD_LAT+7, in the order Q high→low, then I high→low, shifted MSB-first into rsp_rx_q and rsp_rx_i.
  - During read beats and waits, BUS_DATA_OUT = 0.
- **FSM states.**
  - IDLE → CMD on accept.
  - CMD → WRITE for params or tx_iq; CMD → WAIT for status or rx_iq.
  - WAIT → READ when beat = RD_LAT.
  - WRITE / READ → DONE after the last beat.
  - DONE → GAP if IDLE_GAP > 0, else → IDLE.
  - GAP → IDLE after IDLE_GAP cycles.
- **DONE.** rsp_valid = 1 and rsp_op = captured op. The rsp_* data registers update only in DONE and hold their values until the next DONE of the same op.
- **cmd_ready.** High in IDLE, and also in DONE when IDLE_GAP = 0. This allows back-to-back commands: the next command beat falls in the cycle after DONE.
- **Idle bus.** BUS_SYNC = 0 and BUS_DATA_OUT = 0 in IDLE, DONE and GAP.
- **Reset mid-transaction.** All outputs go to their reset values on the reset edge and no rsp_valid is emitted for the aborted transaction. The responder is left mid-sequence; the next command beat resynchronises it, because the responder gives sync priority over everything else.

## Timing
- All outputs are registered. With accept edge A, the command beat is cycle A+1.
- rsp_valid cycle, counted from A:
  - params: A+9.
  - tx_iq: A+10.
  - status: A+RD_LAT+2 (A+4 at default).
  - rx_iq: A+RD_LAT+9 (A+11 at default).
- Transaction throughput: length to rsp_valid plus IDLE_GAP cycles.
- The beat counter is 4 bits and never wraps; the maximum count is 11.

## Structure
- **Shared package stm32_bus_pkg:**
  - op enum;
  - bus codes CMD_PARAMS = 1, CMD_STATUS = 2, CMD_TXIQ = 3, CMD_RXIQ = 4;
  - PARAM_BEATS = 7, IQ_BEATS = 8;
  - flag bit positions TX_BIT = 3, PREAMP_BIT = 2, OTR_BIT = 0.
- **Sub-module stm32_nibble_shifter.** A 32-bit register with nibble shift-out (write path) and nibble shift-in (read path), load, and MSB-first ordering. The top level holds the FSM and the beat counter.

## Test plan
- **params.** preamp = 1, tx = 1, freq = 22'h0977B7 → beat 0: SYNC = 1, nibble 1. Beats 1..7: C, 0, 9, 7, 7, B, 7. rsp_valid at A+9. A responder model reports freq 620471 and tx = 1.
- **tx_iq.** I = 16'h1234, Q = 16'hFEDC → beats 1..8: F, E, D, C, 1, 2, 3, 4. rsp_valid at A+10.
- **rx_iq against a responder model.** Model I = 16'h8001, Q = 16'h7FFE → rsp_rx_q = 16'h7FFE and rsp_rx_i = 16'h8001 at A+11. Repeat with RD_LAT = 3 → rsp_valid at A+12.
- **status.** Responder OTR = 1 → rsp_adc_otr = 1 at A+4. Then OTR = 0 → rsp_adc_otr = 0.
- **Back-to-back.** cmd_valid held high with IDLE_GAP = 0 → the second command beat immediately follows DONE. With IDLE_GAP = 3 → exactly 3 idle cycles with SYNC = 0.
- **Reset mid-transaction.** Reset asserted in beat 4 of rx_iq → all outputs return to reset values, no rsp_valid is emitted, and a following params transaction completes correctly.

Source files
------------

// File: rtl/stm32_bus_pkg.sv
// stm32_bus_pkg: shared op codes, FSM states, bus codes and beat/bit constants for the nibble bus master
package stm32_bus_pkg;
   typedef enum logic [1:0] {
      OP_PARAMS = 2'd0,
      OP_STATUS = 2'd1,
      OP_TXIQ   = 2'd2,
      OP_RXIQ   = 2'd3
   } op_e;
   typedef enum logic [2:0] {
      S_IDLE,
      S_CMD,
      S_WAIT,
      S_WRITE,
      S_READ,
      S_DONE,
      S_GAP
   } state_e;
   localparam logic [3:0] CMD_PARAMS = 4'd1;
   localparam logic [3:0] CMD_STATUS = 4'd2;
   localparam logic [3:0] CMD_TXIQ   = 4'd3;
   localparam logic [3:0] CMD_RXIQ   = 4'd4;
   localparam int PARAM_BEATS = 7;
   localparam int IQ_BEATS    = 8;
   localparam int TX_BIT      = 3;
   localparam int PREAMP_BIT  = 2;
   localparam int OTR_BIT     = 0;
   function automatic logic [3:0] bus_code(input op_e op);
      return op == OP_PARAMS ? CMD_PARAMS :
             op == OP_STATUS ? CMD_STATUS :
             op == OP_TXIQ   ? CMD_TXIQ   : CMD_RXIQ;
   endfunction
endpackage

// File: rtl/stm32_bus_master_if.sv
// stm32_bus_master_if: command/response handshake plus nibble bus signals
//   master modport: bus master view (drives cmd_ready, BUS_*, rsp_*, busy)
//   slave modport : command source / responder view
interface stm32_bus_master_if;
   logic        cmd_valid;
   logic        cmd_ready;
   logic [1:0]  cmd_op;
   logic        cmd_preamp;
   logic        cmd_tx;
   logic [21:0] cmd_freq;
   logic [15:0] cmd_tx_i;
   logic [15:0] cmd_tx_q;
   logic [3:0]  BUS_DATA_OUT;
   logic        BUS_SYNC;
   logic [3:0]  BUS_DATA_IN;
   logic        rsp_valid;
   logic [1:0]  rsp_op;
   logic        rsp_adc_otr;
   logic [15:0] rsp_rx_i;
   logic [15:0] rsp_rx_q;
   logic        busy;
   modport master (
      input  cmd_valid, cmd_op, cmd_preamp, cmd_tx, cmd_freq, cmd_tx_i, cmd_tx_q, BUS_DATA_IN,
      output cmd_ready, BUS_DATA_OUT, BUS_SYNC, rsp_valid, rsp_op, rsp_adc_otr, rsp_rx_i, rsp_rx_q, busy
   );
   modport slave (
      output cmd_valid, cmd_op, cmd_preamp, cmd_tx, cmd_freq, cmd_tx_i, cmd_tx_q, BUS_DATA_IN,
      input  cmd_ready, BUS_DATA_OUT, BUS_SYNC, rsp_valid, rsp_op, rsp_adc_otr, rsp_rx_i, rsp_rx_q, busy
   );
endinterface

// File: rtl/stm32_nibble_shifter.sv
// stm32_nibble_shifter: 32-bit MSB-first nibble shift register
//   i_load/i_load_val : parallel load
//   i_shift_out       : shift left one nibble, o_nib is the nibble leaving
//   i_shift_in/i_nib  : shift left one nibble, i_nib enters at the bottom
//   o_shifted_in      : register value after a shift-in with the current i_nib
module stm32_nibble_shifter (
   input  logic        clk_in,
   input  logic        reset,
   input  logic        i_load,
   input  logic [31:0] i_load_val,
   input  logic        i_shift_out,
   input  logic        i_shift_in,
   input  logic [3:0]  i_nib,
   output logic [3:0]  o_nib,
   output logic [31:0] o_shifted_in
);
   logic [31:0] r_sh;
   assign o_nib        = r_sh[31:28];
   assign o_shifted_in = {r_sh[27:0], i_nib};
   always_ff @(posedge clk_in) begin
      if (reset) r_sh <= '0;
      else if (i_load) r_sh <= i_load_val;
      else if (i_shift_out) r_sh <= {r_sh[27:0], 4'h0};
      else if (i_shift_in) r_sh <= o_shifted_in;
   end
endmodule

// File: rtl/stm32_bus_master.sv
// stm32_bus_master: initiator for the 4-bit nibble bus (command beat, write serialisation, read sampling)
//   clk_in, reset : clock and synchronous active-high reset
//   bus           : command handshake, nibble bus and response signals (master modport)
//   RD_LAT        : beats from command beat to first read sample (1..4)
//   IDLE_GAP      : sync-low gap cycles after each transaction (0..15)
module stm32_bus_master
   import stm32_bus_pkg::*;
#(
   parameter int RD_LAT   = 2,
   parameter int IDLE_GAP = 0
) (
   input logic                 clk_in,
   input logic                 reset,
   stm32_bus_master_if.master  bus
);
   localparam logic [3:0] RD_LAT_B = 4'(RD_LAT);
   localparam logic [3:0] GAP_B    = 4'(IDLE_GAP);
   state_e      r_state, w_state;
   logic [3:0]  r_beat, r_gap;
   op_e         r_op, w_cmd_op;
   logic        r_ready, r_sync, r_rv, r_otr, r_busy;
   logic [3:0]  r_dout, w_flags, w_nib;
   logic [1:0]  r_rop;
   logic [15:0] r_rxi, r_rxq;
   logic [31:0] w_load_val, w_shin;
   logic        w_accept, w_read_op, w_last_wr, w_last_rd;
   assign w_cmd_op  = op_e'(bus.cmd_op);
   assign w_accept  = bus.cmd_valid & r_ready;
   assign w_read_op = r_op == OP_STATUS || r_op == OP_RXIQ;
   assign w_last_wr = r_beat == (r_op == OP_PARAMS ? 4'(PARAM_BEATS) : 4'(IQ_BEATS));
   assign w_last_rd = r_beat == (r_op == OP_STATUS ? RD_LAT_B : RD_LAT_B + 4'(IQ_BEATS - 1));
   always_comb begin
      w_flags             = 4'h0;
      w_flags[TX_BIT]     = bus.cmd_tx;
      w_flags[PREAMP_BIT] = bus.cmd_preamp;
      w_load_val = w_cmd_op == OP_TXIQ ? {bus.cmd_tx_q, bus.cmd_tx_i}
                                       : {w_flags, 2'b00, bus.cmd_freq, 4'h0};
   end
   stm32_nibble_shifter u_sh (
      .clk_in       (clk_in),
      .reset        (reset),
      .i_load       (w_accept),
      .i_load_val   (w_load_val),
      .i_shift_out  (w_state == S_WRITE),
      .i_shift_in   (r_state == S_READ),
      .i_nib        (bus.BUS_DATA_IN),
      .o_nib        (w_nib),
      .o_shifted_in (w_shin)
   );
   // CMD and WAIT share one rule: the read phase starts once the next beat is RD_LAT
   always_comb begin
      w_state = r_state;
      case (r_state)
         S_IDLE:         w_state = w_accept ? S_CMD : S_IDLE;
         S_CMD, S_WAIT:  w_state = !w_read_op ? S_WRITE : r_beat == RD_LAT_B - 4'd1 ? S_READ : S_WAIT;
         S_WRITE:        w_state = w_last_wr ? S_DONE : S_WRITE;
         S_READ:         w_state = w_last_rd ? S_DONE : S_READ;
         S_DONE:         w_state = w_accept ? S_CMD : IDLE_GAP > 0 ? S_GAP : S_IDLE;
         S_GAP:          w_state = r_gap == GAP_B - 4'd1 ? S_IDLE : S_GAP;
         default:        w_state = S_IDLE;
      endcase
   end
   // outputs are registered from the next state so they line up with the state they describe
   always_ff @(posedge clk_in) begin
      if (reset) begin
         r_state <= S_IDLE;
         r_beat  <= 4'd0;
         r_gap   <= 4'd0;
         r_op    <= OP_PARAMS;
         r_ready <= 1'b1;
         r_sync  <= 1'b0;
         r_dout  <= 4'h0;
         r_rv    <= 1'b0;
         r_rop   <= 2'd0;
         r_otr   <= 1'b0;
         r_rxi   <= '0;
         r_rxq   <= '0;
         r_busy  <= 1'b0;
      end else begin
         r_state <= w_state;
         r_beat  <= w_state inside {S_WAIT, S_WRITE, S_READ} ? r_beat + 4'd1 : 4'd0;
         r_gap   <= r_state == S_GAP ? r_gap + 4'd1 : 4'd0;
         if (w_accept) r_op <= w_cmd_op;
         r_ready <= w_state == S_IDLE || (w_state == S_DONE && IDLE_GAP == 0);
         r_sync  <= w_state == S_CMD;
         r_dout  <= w_state == S_CMD ? bus_code(w_cmd_op) : w_state == S_WRITE ? w_nib : 4'h0;
         r_rv    <= w_state == S_DONE;
         r_busy  <= w_state != S_IDLE;
         if (w_state == S_DONE) begin
            r_rop <= r_op;
            if (r_op == OP_STATUS) r_otr <= bus.BUS_DATA_IN[OTR_BIT];
            if (r_op == OP_RXIQ) {r_rxq, r_rxi} <= w_shin;
         end
      end
   end
   assign bus.cmd_ready    = r_ready;
   assign bus.BUS_SYNC     = r_sync;
   assign bus.BUS_DATA_OUT = r_dout;
   assign bus.rsp_valid    = r_rv;
   assign bus.rsp_op       = r_rop;
   assign bus.rsp_adc_otr  = r_otr;
   assign bus.rsp_rx_i     = r_rxi;
   assign bus.rsp_rx_q     = r_rxq;
   assign bus.busy         = r_busy;
endmodule
